alu_op_sequencer: RTL

Control FSM placed between the lab ALU's operand/opcode inputs and its four arithmetic units (adder, subtractor, multiplier, divider). For each `start` request it latches the operands and opcode, asserts the selected unit's `init`, waits for that unit's `done`, then captures the result into a held, zero-extended register with a one-cycle `valid` strobe. It enforces divide-by-zero and timeout error rules, so the display path only ever sees stable, committed results.

---
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus between the ALU operand/opcode front end, the four arithmetic units and the sequencer.
// Handshake: start is taken only while busy=0; valid is a one-cycle strobe with no back-pressure.
interface alu_op_sequencer_if;
  logic       start;
  logic [1:0] opcode;
  logic [2:0] portA;
  logic [2:0] portB;
  logic [3:0] done_i;
  logic [3:0] sal_suma;
  logic [3:0] sal_resta;
  logic [5:0] sal_mult;
  logic [3:0] sal_div;
  logic [3:0] init_o;
  logic [2:0] a_o;
  logic [2:0] b_o;
  logic [1:0] op_o;
  logic [5:0] result;
  logic       valid;
  logic       busy;
  logic       err;

  modport master (
    output start, opcode, portA, portB, done_i, sal_suma, sal_resta, sal_mult, sal_div,
    input  init_o, a_o, b_o, op_o, result, valid, busy, err
  );

  modport slave (
    input  start, opcode, portA, portB, done_i, sal_suma, sal_resta, sal_mult, sal_div,
    output init_o, a_o, b_o, op_o, result, valid, busy, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: latch operands, pulse the chosen unit, wait for done,
// commit a zero-extended result (or an error) with a one-cycle valid strobe.
module alu_op_sequencer #(
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] init_q, init_d;
  logic [2:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [5:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [5:0] sel_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      init_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      init_q   <= init_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Narrow results are zero-extended; the subtractor code is passed through unsigned.
  always_comb begin
    sel_result = '0;
    case (op_q)
      2'd0:    sel_result = {2'b00, bus.sal_suma};
      2'd1:    sel_result = {2'b00, bus.sal_resta};
      2'd2:    sel_result = bus.sal_mult;
      default: sel_result = {2'b00, bus.sal_div};
    endcase
  end

  // Next-state logic; every output is registered from these next values.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    init_d   = init_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        init_d = '0;
        if (bus.start) begin
          a_d   = bus.portA;
          b_d   = bus.portB;
          op_d  = bus.opcode;
          err_d = 1'b0;
          if (bus.opcode == 2'd3 && bus.portB == 3'd0) begin
            state_d  = S_DONE;
            err_d    = 1'b1;
            result_d = '0;
            valid_d  = 1'b1;
          end else begin
            state_d = S_LAUNCH;
            init_d  = 4'b0001 << bus.opcode;
            timer_d = '0;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        // A completion on the last allowed cycle beats the timeout.
        if (bus.done_i[op_q]) begin
          state_d  = S_DONE;
          result_d = sel_result;
          err_d    = 1'b0;
          init_d   = '0;
          valid_d  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d  = S_DONE;
          result_d = '0;
          err_d    = 1'b1;
          init_d   = '0;
          valid_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        init_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.init_o = init_q;
  assign bus.a_o    = a_q;
  assign bus.b_o    = b_q;
  assign bus.op_o   = op_q;
  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;
  assign dbg_state  = state_q;

endmodule
